// File: rtl/eth_vlg_pkg.sv
// eth_vlg_pkg: shared types and constants for the eth_vlg stream blocks.
package eth_vlg_pkg;

    localparam int MON_LEN_W = 16;

    typedef enum logic {IDLE, FRAME} mon_state_t;

    typedef struct packed {
        logic dup_sof;
        logic orphan;
        logic len;
        logic tout;
    } mon_err_t;

    function automatic logic [MON_LEN_W-1:0] len_inc(input logic [MON_LEN_W-1:0] l, input logic [MON_LEN_W-1:0] lim);
        return (l >= lim) ? l : l + 1'b1;
    endfunction

endpackage

// File: rtl/eth_vlg_stream_mon_ch.sv
// eth_vlg_stream_mon_ch: single-channel framing FSM with length/timeout checks,
// sticky errors and saturating packet/abort/error counters.
module eth_vlg_stream_mon_ch
    import eth_vlg_pkg::*;
#(
    parameter int MIN_LEN = 60,
    parameter int MAX_LEN = 1518,
    parameter int TIMEOUT = 2048,
    parameter int CNT_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 val,
    input  logic                 sof,
    input  logic                 eof,
    output logic                 in_frame,
    output mon_err_t             err,
    output logic [MON_LEN_W-1:0] last_len,
    output logic [CNT_W-1:0]     pkt_cnt,
    output logic [CNT_W-1:0]     abort_cnt,
    output logic [CNT_W-1:0]     err_cnt
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [MON_LEN_W-1:0] LEN_MIN = MON_LEN_W'(MIN_LEN);
    localparam logic [MON_LEN_W-1:0] LEN_MAX = MON_LEN_W'(MAX_LEN);
    localparam logic [MON_LEN_W-1:0] LEN_SAT = MON_LEN_W'(MAX_LEN + 1);
    localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT - 1);

    mon_state_t st_q, st_d;
    logic [MON_LEN_W-1:0] len_q, len_d, last_len_q, last_len_d, done_len;
    logic [TW-1:0] tout_q, tout_d;
    mon_err_t err_q, err_d, ev;
    logic [CNT_W-1:0] pkt_q, pkt_d, abort_q, abort_d, errc_q, errc_d;
    logic done, abort, tout_hit;

    // clear happens first so that a same-cycle event still lands in the counter
    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic z, input logic inc);
        logic [CNT_W-1:0] b;
        b = z ? '0 : c;
        return (inc && !(&b)) ? b + 1'b1 : b;
    endfunction

    assign tout_hit = !val && tout_q == TOUT_LAST;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q       <= IDLE;
            len_q      <= '0;
            tout_q     <= '0;
            last_len_q <= '0;
            err_q      <= '0;
            pkt_q      <= '0;
            abort_q    <= '0;
            errc_q     <= '0;
        end else begin
            st_q       <= st_d;
            len_q      <= len_d;
            tout_q     <= tout_d;
            last_len_q <= last_len_d;
            err_q      <= err_d;
            pkt_q      <= pkt_d;
            abort_q    <= abort_d;
            errc_q     <= errc_d;
        end
    end

    always_comb begin
        st_d = st_q;
        if (val && sof) st_d = eof ? IDLE : FRAME;
        else if (st_q == FRAME && (val ? eof : tout_hit)) st_d = IDLE;
    end

    always_comb begin
        len_d    = len_q;
        tout_d   = tout_q;
        ev       = '0;
        done     = 1'b0;
        abort    = 1'b0;
        done_len = len_inc(len_q, LEN_SAT);
        if (val && sof) begin
            ev.dup_sof = st_q == FRAME;
            abort      = st_q == FRAME;
            len_d      = MON_LEN_W'(1);
            tout_d     = '0;
            done       = eof;
            done_len   = MON_LEN_W'(1);
        end else if (st_q == IDLE) begin
            ev.orphan = val;
        end else if (val) begin
            len_d  = len_inc(len_q, LEN_SAT);
            tout_d = '0;
            done   = eof;
        end else begin
            tout_d = tout_hit ? '0 : tout_q + 1'b1;
            ev.tout = tout_hit;
            abort   = tout_hit;
        end
        ev.len = done && (done_len < LEN_MIN || done_len > LEN_MAX);
    end

    always_comb begin
        err_d      = (clr ? '0 : err_q) | ev;
        last_len_d = done ? done_len : last_len_q;
        pkt_d      = bump(pkt_q, clr, done && !ev.len);
        abort_d    = bump(abort_q, clr, abort);
        errc_d     = bump(errc_q, clr, |ev);
    end

    assign in_frame  = st_q == FRAME;
    assign err       = err_q;
    assign last_len  = last_len_q;
    assign pkt_cnt   = pkt_q;
    assign abort_cnt = abort_q;
    assign err_cnt   = errc_q;

endmodule

// File: rtl/eth_vlg_stream_mon.sv
// eth_vlg_stream_mon: N_CH independent stream-framing monitors with flattened
// status buses and a global error summary.
module eth_vlg_stream_mon
    import eth_vlg_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int MIN_LEN = 60,
    parameter int MAX_LEN = 1518,
    parameter int TIMEOUT = 2048,
    parameter int CNT_W   = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic [N_CH-1:0]           val,
    input  logic [N_CH-1:0]           sof,
    input  logic [N_CH-1:0]           eof,
    output logic [N_CH-1:0]           in_frame,
    output logic [N_CH-1:0]           err_dup_sof,
    output logic [N_CH-1:0]           err_orphan,
    output logic [N_CH-1:0]           err_len,
    output logic [N_CH-1:0]           err_tout,
    output logic                      any_err,
    output logic [N_CH*MON_LEN_W-1:0] last_len,
    output logic [N_CH*CNT_W-1:0]     pkt_cnt,
    output logic [N_CH*CNT_W-1:0]     abort_cnt,
    output logic [N_CH*CNT_W-1:0]     err_cnt
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        mon_err_t e;
        eth_vlg_stream_mon_ch #(
            .MIN_LEN (MIN_LEN),
            .MAX_LEN (MAX_LEN),
            .TIMEOUT (TIMEOUT),
            .CNT_W   (CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .clr       (clr),
            .val       (val[i]),
            .sof       (sof[i]),
            .eof       (eof[i]),
            .in_frame  (in_frame[i]),
            .err       (e),
            .last_len  (last_len[i*MON_LEN_W +: MON_LEN_W]),
            .pkt_cnt   (pkt_cnt[i*CNT_W +: CNT_W]),
            .abort_cnt (abort_cnt[i*CNT_W +: CNT_W]),
            .err_cnt   (err_cnt[i*CNT_W +: CNT_W])
        );
        assign err_dup_sof[i] = e.dup_sof;
        assign err_orphan[i]  = e.orphan;
        assign err_len[i]     = e.len;
        assign err_tout[i]    = e.tout;
    end

    assign any_err = |{err_dup_sof, err_orphan, err_len, err_tout};

endmodule

// File: tb/tb_eth_vlg_stream_mon.sv
// tb_eth_vlg_stream_mon: directed frame vectors plus hand-written dup-sof,
// timeout, orphan-with-clear and mid-frame reset sequences.
module tb_eth_vlg_stream_mon;

    logic clk, rst, clr;
    logic [3:0] val, sof, eof;
    logic [3:0] in_frame, err_dup_sof, err_orphan, err_len, err_tout;
    logic any_err;
    logic [63:0] last_len;
    logic [127:0] pkt_cnt, abort_cnt, err_cnt;
    logic [3:0] in_frame_1, err_dup_sof_1, err_orphan_1, err_len_1, err_tout_1;
    logic any_err_1;
    logic [63:0] last_len_1;
    logic [127:0] pkt_cnt_1, abort_cnt_1, err_cnt_1;

    int n_cmp = 0;
    int n_bad = 0;

    eth_vlg_stream_mon dut (
        .clk(clk), .rst(rst), .clr(clr), .val(val), .sof(sof), .eof(eof),
        .in_frame(in_frame), .err_dup_sof(err_dup_sof), .err_orphan(err_orphan),
        .err_len(err_len), .err_tout(err_tout), .any_err(any_err),
        .last_len(last_len), .pkt_cnt(pkt_cnt), .abort_cnt(abort_cnt), .err_cnt(err_cnt)
    );

    eth_vlg_stream_mon #(.MIN_LEN(1)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .val(val), .sof(sof), .eof(eof),
        .in_frame(in_frame_1), .err_dup_sof(err_dup_sof_1), .err_orphan(err_orphan_1),
        .err_len(err_len_1), .err_tout(err_tout_1), .any_err(any_err_1),
        .last_len(last_len_1), .pkt_cnt(pkt_cnt_1), .abort_cnt(abort_cnt_1), .err_cnt(err_cnt_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired, got running, expected finished");
        $fatal(1);
    end

    typedef struct {
        int ch;
        int n;
        int pkt;
        int elen;
        int last;
    } vec_t;

    vec_t tbl [8];

    function automatic logic [31:0] cnt(input logic [127:0] v, input int c);
        logic [127:0] t;
        t = v >> (c * 32);
        return t[31:0];
    endfunction

    function automatic logic [31:0] ln(input logic [63:0] v, input int c);
        logic [63:0] t;
        t = v >> (c * 16);
        return {16'b0, t[15:0]};
    endfunction

    function automatic logic [31:0] bt(input logic [3:0] v, input int c);
        logic [3:0] t;
        t = v >> c;
        return {31'b0, t[0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int c, input logic s, input logic e);
        val = 4'(1) << c;
        sof = s ? 4'(1) << c : 4'b0;
        eof = e ? 4'(1) << c : 4'b0;
        tick();
        val = '0;
        sof = '0;
        eof = '0;
    endtask

    task automatic send_frame(input int c, input int n);
        for (int b = 0; b < n; b++) beat(c, b == 0, b == n - 1);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        tbl[0] = '{0, 64,   1, 0, 64};
        tbl[1] = '{1, 10,   0, 1, 10};
        tbl[2] = '{2, 59,   0, 1, 59};
        tbl[3] = '{3, 60,   1, 0, 60};
        tbl[4] = '{0, 1518, 1, 0, 1518};
        tbl[5] = '{1, 1519, 0, 1, 1519};
        tbl[6] = '{2, 1600, 0, 1, 1519};
        tbl[7] = '{3, 1,    0, 1, 1};
        rst = 1'b0;
        clr = 1'b0;
        val = '0;
        sof = '0;
        eof = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_frame", 32'(in_frame), 0);
        chk("rst_any_err", 32'(any_err), 0);
        chk("rst_counters", 32'(|{pkt_cnt, abort_cnt, err_cnt}), 0);
        chk("rst_last_len", 32'(|last_len), 0);
        rst = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            int c;
            int others;
            c = tbl[i].ch;
            do_clr();
            send_frame(c, tbl[i].n);
            others = 0;
            for (int k = 0; k < 4; k++) if (k != c) others += int'(cnt(pkt_cnt, k));
            chk($sformatf("v%0d_pkt", i), cnt(pkt_cnt, c), 32'(tbl[i].pkt));
            chk($sformatf("v%0d_err_len", i), bt(err_len, c), 32'(tbl[i].elen));
            chk($sformatf("v%0d_last_len", i), ln(last_len, c), 32'(tbl[i].last));
            chk($sformatf("v%0d_err_cnt", i), cnt(err_cnt, c), 32'(tbl[i].elen));
            chk($sformatf("v%0d_any_err", i), 32'(any_err), 32'(tbl[i].elen));
            chk($sformatf("v%0d_in_frame", i), 32'(in_frame), 0);
            chk($sformatf("v%0d_other_pkt", i), 32'(others), 0);
        end
        // duplicate sof restarts the frame; the restarted 60-beat frame is good
        do_clr();
        beat(2, 1, 0);
        repeat (4) beat(2, 0, 0);
        beat(2, 1, 0);
        chk("dup_abort_lat", cnt(abort_cnt, 2), 1);
        chk("dup_in_frame", bt(in_frame, 2), 1);
        repeat (58) beat(2, 0, 0);
        beat(2, 0, 1);
        chk("dup_err_dup_sof", bt(err_dup_sof, 2), 1);
        chk("dup_abort_cnt", cnt(abort_cnt, 2), 1);
        chk("dup_pkt_cnt", cnt(pkt_cnt, 2), 1);
        chk("dup_last_len", ln(last_len, 2), 60);
        chk("dup_err_len", bt(err_len, 2), 0);
        chk("dup_err_cnt", cnt(err_cnt, 2), 1);
        // timeout fires on the 2048th consecutive idle cycle
        do_clr();
        beat(3, 1, 0);
        repeat (2047) tick();
        chk("tout_early_in_frame", bt(in_frame, 3), 1);
        chk("tout_early_err", bt(err_tout, 3), 0);
        tick();
        chk("tout_err", bt(err_tout, 3), 1);
        chk("tout_in_frame", bt(in_frame, 3), 0);
        chk("tout_abort_cnt", cnt(abort_cnt, 3), 1);
        chk("tout_err_cnt", cnt(err_cnt, 3), 1);
        // orphan eof in the same cycle as clr survives the clear
        send_frame(0, 60);
        chk("orph_pre_pkt", cnt(pkt_cnt, 0), 1);
        clr = 1'b1;
        val = 4'b0001;
        eof = 4'b0001;
        tick();
        clr = 1'b0;
        val = '0;
        eof = '0;
        chk("orph_err_orphan", bt(err_orphan, 0), 1);
        chk("orph_err_cnt", cnt(err_cnt, 0), 1);
        chk("orph_pkt_cnt", cnt(pkt_cnt, 0), 0);
        chk("orph_tout_cleared", 32'(err_tout), 0);
        // asynchronous reset mid-frame on every channel
        val = 4'hf;
        sof = 4'hf;
        tick();
        val = '0;
        sof = '0;
        chk("rstmid_in_frame_pre", 32'(in_frame), 32'hf);
        #2;
        rst = 1'b0;
        #1;
        chk("rstmid_in_frame", 32'(in_frame), 0);
        chk("rstmid_in_frame_1", 32'(in_frame_1), 0);
        chk("rstmid_counters", 32'(|{pkt_cnt, err_cnt, abort_cnt}), 0);
        tick();
        rst = 1'b1;
        tick();
        beat(0, 1, 1);
        chk("single_pkt_min1", cnt(pkt_cnt_1, 0), 1);
        chk("single_last_len_min1", ln(last_len_1, 0), 1);
        chk("single_err_len_min1", bt(err_len_1, 0), 0);
        chk("single_pkt_min60", cnt(pkt_cnt, 0), 0);
        chk("single_err_len_min60", bt(err_len, 0), 1);
        chk("single_last_len_min60", ln(last_len, 0), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
